midi_ctrl_bank: RTL and testbench
=================================

Name: midi_ctrl_bank

Overview:
Multi-channel MIDI controller store, the parametrised successor to the single-channel pitch-bend capture. It takes decoded controller and pitch-bend events from the MIDI decoder for CHANNELS MIDI channels and keeps:
- one 14-bit pitch-bend value per channel;
- a 128-entry 7-bit CC table per channel.
It exposes a registered random-access read port to the voice/parameter logic and handles "Reset All Controllers" (CC 121) with a clear sweep. Everything runs in the CLOCK_25 domain.

Parameters:
CHANNELS, 16, number of MIDI channels stored (1..16)
CH_WIDTH, 4, width of channel index ports
PB_CENTER, 8192, pitch-bend reset/centre value (14-bit)
SLEW_STEP, 64, pitch slew increment per step (PITCH_SLEW_EN only)
SLEW_DIV, 256, clocks per slew step (PITCH_SLEW_EN only)

Ports:
CLOCK_25  in  1  system clock; all logic on rising edge
reset_reg_N  in  1  asynchronous active-low reset
ictrl  in  8  data byte 1: CC number / pitch LSB; bit 7 ignored
ictrl_data  in  8  data byte 2: CC value / pitch MSB; bit 7 ignored
ichan  in  CH_WIDTH  MIDI channel of the current event
ctrl_cmd  in  1  CC event strobe (level, synchronous)
pitch_cmd  in  1  pitch-bend event strobe (level, synchronous)
rd_chan  in  CH_WIDTH  read channel
rd_cc  in  7  read CC number
rd_data  out  7  CC value at rd_chan/rd_cc
rd_cc14  out  14  paired 14-bit CC value
pitch_val  out  14*CHANNELS  per-channel pitch bend; channel n at bits [14n+13:14n]
pitch_upd  out  CHANNELS  1-cycle pulse when a channel's pitch_val changes
cc_upd  out  1  1-cycle pulse when a CC write commits
busy  out  1  clear sweep in progress
ovf  out  1  sticky: an event was dropped

Behaviour:
Interface:
- One clock, CLOCK_25. reset_reg_N is asynchronous and active-low.

Reset values:
- pitch_val: every channel = PB_CENTER.
- rd_data = 0, rd_cc14 = 0.
- pitch_upd = 0, cc_upd = 0, ovf = 0.
- busy = 1. FSM enters INIT_CLR.

Event detect:
- ctrl_cmd and pitch_cmd are each registered once.
- An event is a rising edge: cmd=1 and cmd_r=0. ictrl, ictrl_data and ichan are sampled on that same cycle.
- If both strobes rise on the same cycle, both are processed, pitch first; CC is held in the pending slot.
- Events with ichan >= CHANNELS are discarded silently (no ovf).

Pitch event:
- Processed in any FSM state.
- Target is {ictrl_data[6:0], ictrl[6:0]}. pitch_val[ch] updates 1 cycle after the detect cycle.
- pitch_upd[ch] pulses on that same cycle.

CC event in IDLE:
- Commits mem[ch][ictrl[6:0]] = ictrl_data[6:0] 1 cycle after detect; cc_upd pulses on that cycle.
- CC 121 is not stored. It sets pitch_val[ch] = PB_CENTER (pitch_upd[ch] pulses) and enters CH_CLR for ch.

CC event while busy:
- Captured into a 1-entry pending slot.
- If the slot is already full, the new event is dropped and ovf is set. ovf clears only on reset.
- The slot is replayed the cycle after the FSM returns to IDLE.

FSM:
- INIT_CLR: after reset, write 0 to all CHANNELS*128 entries, one per clock, channel-major. Takes CHANNELS*128 cycles, then IDLE.
- IDLE: busy=0.
- CH_CLR: write 0 to CC 0..119 of the latched channel, one per clock (120 cycles). CC 120..127 are untouched. Then IDLE.
- busy=1 in both clear states. A CC 121 arriving during a clear follows the pending-slot rule.
- Reset asserted mid-sweep aborts the sweep; INIT_CLR restarts from entry 0.

Read port:
- Latency is 1 cycle: rd_data and rd_cc14 reflect the rd_chan/rd_cc presented on the previous edge.
- Read-first: a read of an address written on the same cycle returns the old value.
- Reads during busy return the current partially cleared contents.
- rd_cc14 = {mem[cc], mem[cc+32]} for rd_cc < 32; otherwise {mem[cc], 7'd0}.
- rd_chan >= CHANNELS returns 0.

Optional Feature:
PITCH_SLEW_EN
- Defined: each channel keeps a 14-bit target. A shared counter wraps every SLEW_DIV clocks. On each wrap, every pitch_val steps toward its target by SLEW_STEP, clamped so it never overshoots; pitch_upd pulses per channel on each step that changes the value. CC 121 and reset load PB_CENTER directly, with no slew.
- Not defined: pitch_val loads the target immediately as described above. No counter is built.

Test Plan:
- Reset release -> busy=1 for exactly CHANNELS*128 cycles (2048) then 0; all pitch_val=8192; read ch3 cc7 -> rd_data=0.
- Pitch on ch2: ictrl=0x05, ictrl_data=0x40 -> pitch_val[2]=0x2005 one cycle after the edge; pitch_upd=0x0004 for 1 cycle; other channels stay 8192.
- CC ch0 cc1=0x12 and cc33=0x34 -> read rd_cc=1 gives rd_data=0x12 and rd_cc14=0x0934.
- CC 121 on ch5 after ch5 cc10=0x7F and cc120=0x11 -> busy high 120 cycles; cc10 reads 0, cc120 reads 0x11; pitch_val[5]=8192.
- During a CH_CLR, send two CC events -> first commits after busy drops; second dropped, ovf=1 until reset.
- PITCH_SLEW_EN, SLEW_STEP=64, SLEW_DIV=4: pitch 8192→8400 -> values 8256, 8320, 8384, 8400 at 4-clock intervals.

Source files
------------

// File: rtl/midi_ctrl_bank.sv
// midi_ctrl_bank: multi-channel MIDI controller store.
//   Holds one 14-bit pitch-bend value and a 128-entry 7-bit CC table per
//   channel. It has a registered random-access read port. CC 121 ("Reset All
//   Controllers") clears CC 0..119 of its channel with a one-per-clock sweep.
//   After reset, every table entry is cleared by the same sweep mechanism.
// Optional feature macro: PITCH_SLEW_EN
//   When this macro is defined, pitch_val slews toward the per-channel target.
//   When it is not defined, pitch_val loads the target directly.
// Ports:
//   CLOCK_25, reset_reg_N : clock, asynchronous active-low reset
//   ictrl, ictrl_data     : event data bytes (bit 7 ignored)
//   ichan                 : event channel
//   ctrl_cmd, pitch_cmd   : level strobes; a rising edge is an event
//   rd_chan, rd_cc        : read address; rd_data / rd_cc14 follow one clock later
//   pitch_val, pitch_upd  : per-channel pitch bend and its change pulse
//   cc_upd                : pulse when a CC write commits
//   busy                  : clear sweep in progress
//   ovf                   : sticky; a CC event was dropped because the pending slot was full
`timescale 1ns/1ps
module midi_ctrl_bank #(
   parameter int CHANNELS  = 16,
   parameter int CH_WIDTH  = 4,
   parameter int PB_CENTER = 8192,
   parameter int SLEW_STEP = 64,
   parameter int SLEW_DIV  = 256
) (
   input  logic                     CLOCK_25,
   input  logic                     reset_reg_N,
   input  logic [7:0]               ictrl,
   input  logic [7:0]               ictrl_data,
   input  logic [CH_WIDTH-1:0]      ichan,
   input  logic                     ctrl_cmd,
   input  logic                     pitch_cmd,
   input  logic [CH_WIDTH-1:0]      rd_chan,
   input  logic [6:0]               rd_cc,
   output logic [6:0]               rd_data,
   output logic [13:0]              rd_cc14,
   output logic [14*CHANNELS-1:0]   pitch_val,
   output logic [CHANNELS-1:0]      pitch_upd,
   output logic                     cc_upd,
   output logic                     busy,
   output logic                     ovf
);
   localparam int AW = CH_WIDTH + 7;
   localparam int LAST_ENTRY = CHANNELS * 128 - 1;
   localparam logic [13:0] CENTER = 14'(PB_CENTER);

   typedef enum logic [1:0] {INIT_CLR, IDLE, CH_CLR} state_t;
   state_t state_reg, state_next;

   logic ctrl_r, pitch_r, ev_chan_ok, rd_chan_ok;
   logic pitch_ev, ctrl_ev;
   logic pend_valid_reg;
   logic [CH_WIDTH-1:0] pend_ch_reg;
   logic [6:0] pend_cc_reg, pend_val_reg;
   logic [AW-1:0] clr_idx_reg;
   logic cc_upd_reg, ovf_reg;
   logic [6:0] rd_data_reg;
   logic [13:0] rd_cc14_reg;
   logic [13:0] pitch_target;
   logic [6:0] mem [1 << AW];

   logic cc_go, direct, pend_take, pend_load, drop, cc121, cc_commit;
   logic mem_we, clr_load, clr_inc;
   logic [CH_WIDTH-1:0] cc_ch;
   logic [6:0] cc_num, cc_val, mem_wdata;
   logic [AW-1:0] mem_addr, rd_addr, rd_pair_addr;

   logic unused_bits;
   assign unused_bits = ictrl[7] ^ ictrl_data[7];

   // When the channel field can only hold valid channels, no range check is needed.
   generate
      if (CHANNELS >= (1 << CH_WIDTH)) begin : g_full_range
         assign ev_chan_ok = 1'b1;
         assign rd_chan_ok = 1'b1;
      end else begin : g_part_range
         assign ev_chan_ok = (32'(ichan) < CHANNELS);
         assign rd_chan_ok = (32'(rd_chan) < CHANNELS);
      end
   endgenerate

   assign pitch_ev     = pitch_cmd & ~pitch_r & ev_chan_ok;
   assign ctrl_ev      = ctrl_cmd & ~ctrl_r & ev_chan_ok;
   assign pitch_target = {ictrl_data[6:0], ictrl[6:0]};

   always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
      if (!reset_reg_N) state_reg <= INIT_CLR;
      else              state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      cc_go      = 1'b0;
      direct     = 1'b0;
      pend_take  = 1'b0;
      pend_load  = 1'b0;
      drop       = 1'b0;
      cc121      = 1'b0;
      cc_commit  = 1'b0;
      mem_we     = 1'b0;
      clr_load   = 1'b0;
      clr_inc    = 1'b0;
      cc_ch      = ichan;
      cc_num     = ictrl[6:0];
      cc_val     = ictrl_data[6:0];
      mem_addr   = clr_idx_reg;
      mem_wdata  = 7'd0;
      case (state_reg)
         INIT_CLR: begin
            mem_we = 1'b1;
            if (clr_idx_reg == AW'(LAST_ENTRY)) state_next = IDLE;
            else                                clr_inc    = 1'b1;
         end
         CH_CLR: begin
            mem_we = 1'b1;
            if (clr_idx_reg[6:0] == 7'd119) state_next = IDLE;
            else                            clr_inc    = 1'b1;
         end
         IDLE: begin
            // The pending slot is older than any new event, so it is served first.
            if (pend_valid_reg) begin
               cc_go     = 1'b1;
               pend_take = 1'b1;
               cc_ch     = pend_ch_reg;
               cc_num    = pend_cc_reg;
               cc_val    = pend_val_reg;
            end else if (ctrl_ev && !pitch_ev) begin
               cc_go  = 1'b1;
               direct = 1'b1;
            end
         end
         default: state_next = INIT_CLR;
      endcase
      if (cc_go) begin
         if (cc_num == 7'd121) begin
            cc121      = 1'b1;
            clr_load   = 1'b1;
            state_next = CH_CLR;
         end else begin
            mem_we    = 1'b1;
            mem_addr  = {cc_ch, cc_num};
            mem_wdata = cc_val;
            cc_commit = 1'b1;
         end
      end
      // A CC event that is not committed this cycle waits in the slot.
      // The slot can be reloaded in the same cycle that it is replayed.
      if (ctrl_ev && !direct) begin
         if (!pend_valid_reg || pend_take) pend_load = 1'b1;
         else                              drop      = 1'b1;
      end
   end

   always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         ctrl_r         <= 1'b0;
         pitch_r        <= 1'b0;
         clr_idx_reg    <= '0;
         pend_valid_reg <= 1'b0;
         pend_ch_reg    <= '0;
         pend_cc_reg    <= '0;
         pend_val_reg   <= '0;
         cc_upd_reg     <= 1'b0;
         ovf_reg        <= 1'b0;
      end else begin
         ctrl_r     <= ctrl_cmd;
         pitch_r    <= pitch_cmd;
         cc_upd_reg <= cc_commit;
         ovf_reg    <= ovf_reg | drop;
         if (clr_load)     clr_idx_reg <= {cc_ch, 7'd0};
         else if (clr_inc) clr_idx_reg <= clr_idx_reg + 1'b1;
         if (pend_load) begin
            pend_valid_reg <= 1'b1;
            pend_ch_reg    <= ichan;
            pend_cc_reg    <= ictrl[6:0];
            pend_val_reg   <= ictrl_data[6:0];
         end else if (pend_take) begin
            pend_valid_reg <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLOCK_25) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   // CC n (n < 32) pairs with CC n+32 as its LSB.
   assign rd_addr      = {rd_chan, rd_cc};
   assign rd_pair_addr = {rd_chan, 2'b01, rd_cc[4:0]};

   always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         rd_data_reg <= '0;
         rd_cc14_reg <= '0;
      end else if (!rd_chan_ok) begin
         rd_data_reg <= '0;
         rd_cc14_reg <= '0;
      end else begin
         rd_data_reg <= mem[rd_addr];
         rd_cc14_reg <= {mem[rd_addr], (rd_cc[6:5] == 2'b00) ? mem[rd_pair_addr] : 7'd0};
      end
   end

`ifdef PITCH_SLEW_EN
   localparam int SW = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
   localparam logic [13:0] STEP = 14'(SLEW_STEP);
   logic [SW-1:0] slew_cnt_reg;
   logic slew_tick;
   assign slew_tick = (slew_cnt_reg == SW'(SLEW_DIV - 1));

   always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
      if (!reset_reg_N)   slew_cnt_reg <= '0;
      else if (slew_tick) slew_cnt_reg <= '0;
      else                slew_cnt_reg <= slew_cnt_reg + 1'b1;
   end
`else
   logic unused_slew_params;
   assign unused_slew_params = ^{32'(SLEW_STEP), 32'(SLEW_DIV)};
`endif

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         logic [13:0] pv_reg;
         logic upd_reg, hit_pitch, hit_c121;
         assign hit_pitch = pitch_ev && (ichan == CH_WIDTH'(gi));
         assign hit_c121  = cc121 && (cc_ch == CH_WIDTH'(gi));
`ifdef PITCH_SLEW_EN
         logic [13:0] tgt_reg, slew_next;
         always_comb begin
            slew_next = tgt_reg;
            if (pv_reg < tgt_reg) begin
               if (tgt_reg - pv_reg > STEP) slew_next = pv_reg + STEP;
            end else begin
               if (pv_reg - tgt_reg > STEP) slew_next = pv_reg - STEP;
            end
         end
         always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
            if (!reset_reg_N) begin
               pv_reg  <= CENTER;
               tgt_reg <= CENTER;
               upd_reg <= 1'b0;
            end else begin
               upd_reg <= 1'b0;
               if (hit_c121) begin
                  pv_reg  <= CENTER;
                  tgt_reg <= CENTER;
                  upd_reg <= 1'b1;
               end else begin
                  if (hit_pitch) tgt_reg <= pitch_target;
                  if (slew_tick && (pv_reg != tgt_reg)) begin
                     pv_reg  <= slew_next;
                     upd_reg <= 1'b1;
                  end
               end
            end
         end
`else
         // A replayed CC 121 is applied after a same-cycle pitch event, so it wins.
         always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
            if (!reset_reg_N) begin
               pv_reg  <= CENTER;
               upd_reg <= 1'b0;
            end else begin
               upd_reg <= hit_pitch | hit_c121;
               if (hit_c121)       pv_reg <= CENTER;
               else if (hit_pitch) pv_reg <= pitch_target;
            end
         end
`endif
         assign pitch_val[14*gi +: 14] = pv_reg;
         assign pitch_upd[gi]          = upd_reg;
      end
   endgenerate

   assign rd_data = rd_data_reg;
   assign rd_cc14 = rd_cc14_reg;
   assign cc_upd  = cc_upd_reg;
   assign ovf     = ovf_reg;
   assign busy    = (state_reg != IDLE);
endmodule

// File: tb/tb_midi_ctrl_bank.sv
`timescale 1ns/1ps
module tb_midi_ctrl_bank;
   localparam int CH = 16;

   logic CLOCK_25 = 1'b0;
   always #5 CLOCK_25 = ~CLOCK_25;

   logic reset_reg_N;
   logic [7:0] ictrl, ictrl_data;
   logic [3:0] ichan, rd_chan;
   logic ctrl_cmd, pitch_cmd;
   logic [6:0] rd_cc, rd_data;
   logic [13:0] rd_cc14;
   logic [14*CH-1:0] pitch_val;
   logic [CH-1:0] pitch_upd;
   logic cc_upd, busy, ovf;

   midi_ctrl_bank dut (
      .CLOCK_25(CLOCK_25), .reset_reg_N(reset_reg_N),
      .ictrl(ictrl), .ictrl_data(ictrl_data), .ichan(ichan),
      .ctrl_cmd(ctrl_cmd), .pitch_cmd(pitch_cmd),
      .rd_chan(rd_chan), .rd_cc(rd_cc), .rd_data(rd_data), .rd_cc14(rd_cc14),
      .pitch_val(pitch_val), .pitch_upd(pitch_upd), .cc_upd(cc_upd),
      .busy(busy), .ovf(ovf)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   logic rd_req = 1'b0;
   logic rd_req_d = 1'b0;

   typedef struct { int due; logic [CH-1:0] mask; logic [14*CH-1:0] val; } pexp_t;
   typedef struct { logic [6:0] d; logic [13:0] w; } rexp_t;
   pexp_t pq[$];
   int    cq[$];
   rexp_t rq[$];
   logic [13:0] model_p [CH];
   pexp_t mon_p;
   rexp_t mon_r;
   int    mon_c;

   always @(posedge CLOCK_25) begin
      cyc      <= cyc + 1;
      rd_req_d <= rd_req;
   end

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic logic [14*CH-1:0] pvec();
      logic [14*CH-1:0] v;
      for (int i = 0; i < CH; i++) v[14*i +: 14] = model_p[i];
      return v;
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents an update or read result.
   always @(negedge CLOCK_25) begin
      if (reset_reg_N) begin
         if (pitch_upd != '0) begin
            if (pq.size() == 0) chk("pitch_upd unexpected", pitch_upd, 0);
            else begin
               mon_p = pq.pop_front();
               chk("pitch_upd mask", pitch_upd, mon_p.mask);
               chk("pitch_val", pitch_val, mon_p.val);
               if (mon_p.due >= 0) chk("pitch latency", cyc, mon_p.due);
               $display("pitch update mask=%04h cyc=%0d", pitch_upd, cyc);
            end
         end
         if (cc_upd) begin
            if (cq.size() == 0) chk("cc_upd unexpected", cc_upd, 0);
            else begin
               mon_c = cq.pop_front();
               if (mon_c >= 0) chk("cc latency", cyc, mon_c);
               $display("cc commit cyc=%0d", cyc);
            end
         end
         if (rd_req_d) begin
            if (rq.size() == 0) chk("read unexpected", 1, 0);
            else begin
               mon_r = rq.pop_front();
               chk("rd_data", rd_data, mon_r.d);
               chk("rd_cc14", rd_cc14, mon_r.w);
               $display("read rd_data=%02h rd_cc14=%04h", rd_data, rd_cc14);
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLOCK_25);
      #1;
   endtask

   task automatic rd(input int ch, input int cc, input logic [6:0] d, input logic [13:0] w);
      rd_chan = 4'(ch);
      rd_cc   = 7'(cc);
      rd_req  = 1'b1;
      rq.push_back('{d, w});
      tick();
      rd_req = 1'b0;
   endtask

   task automatic pitch_ev(input int ch, input logic [7:0] lsb, input logic [7:0] msb);
      pexp_t p;
      tick();
      ichan = 4'(ch); ictrl = lsb; ictrl_data = msb; pitch_cmd = 1'b1;
      model_p[ch] = {msb[6:0], lsb[6:0]};
      p.due = cyc + 1; p.mask = CH'(1) << ch; p.val = pvec();
      pq.push_back(p);
      tick();
      pitch_cmd = 1'b0;
   endtask

   // due_off: 1 = commits next cycle, -1 = commits later, 0 = no commit expected
   task automatic cc_ev(input int ch, input int cc, input logic [7:0] val, input int due_off);
      pexp_t p;
      tick();
      ichan = 4'(ch); ictrl = 8'(cc); ictrl_data = val; ctrl_cmd = 1'b1;
      if (due_off == 1) cq.push_back(cyc + 1);
      if (due_off < 0)  cq.push_back(-1);
      if (cc == 121) begin
         model_p[ch] = 14'd8192;
         p.due = cyc + 1; p.mask = CH'(1) << ch; p.val = pvec();
         pq.push_back(p);
      end
      tick();
      ctrl_cmd = 1'b0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      @(negedge CLOCK_25);
      while (busy === 1'b1 && n < 5000) begin
         n++;
         @(negedge CLOCK_25);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      pexp_t p;
      for (int i = 0; i < CH; i++) model_p[i] = 14'd8192;
      reset_reg_N = 1'b0; ictrl = '0; ictrl_data = '0; ichan = '0;
      ctrl_cmd = 1'b0; pitch_cmd = 1'b0; rd_chan = '0; rd_cc = '0;
      repeat (3) @(posedge CLOCK_25);
      @(negedge CLOCK_25);
      chk("reset busy", busy, 1);
      chk("reset rd_data", rd_data, 0);
      chk("reset rd_cc14", rd_cc14, 0);
      chk("reset pitch_upd", pitch_upd, 0);
      chk("reset cc_upd", cc_upd, 0);
      chk("reset ovf", ovf, 0);
      chk("reset pitch_val", pitch_val, pvec());
      tick();
      reset_reg_N = 1'b1;
      count_busy(n);
      chk("init busy cycles", n, 2048);
      tick();

      rd(3, 7, 7'h00, 14'h0000);
      pitch_ev(2, 8'h05, 8'h40);            // 0x2005
      repeat (2) tick();

      cc_ev(0, 1, 8'h12, 1);
      cc_ev(0, 33, 8'h34, 1);
      rd(0, 1, 7'h12, 14'h0934);
      rd(0, 33, 7'h34, 14'h1A00);
      rd(1, 1, 7'h00, 14'h0000);

      // Read-first: write ch0 cc1 and read it on the same edge.
      tick();
      ichan = 4'd0; ictrl = 8'd1; ictrl_data = 8'h13; ctrl_cmd = 1'b1;
      cq.push_back(cyc + 1);
      rd_chan = 4'd0; rd_cc = 7'd1; rd_req = 1'b1;
      rq.push_back('{7'h12, 14'h0934});
      tick();
      ctrl_cmd = 1'b0; rd_req = 1'b0;
      rd(0, 1, 7'h13, 14'h09B4);

      // Pitch and CC rising together on ch1: pitch commits first, CC one cycle later.
      tick();
      ichan = 4'd1; ictrl = 8'h04; ictrl_data = 8'h22;
      pitch_cmd = 1'b1; ctrl_cmd = 1'b1;
      model_p[1] = 14'h1104;
      p.due = cyc + 1; p.mask = 16'h0002; p.val = pvec();
      pq.push_back(p);
      cq.push_back(cyc + 2);
      tick();
      pitch_cmd = 1'b0; ctrl_cmd = 1'b0;
      repeat (2) tick();
      rd(1, 4, 7'h22, 14'h1100);

      // CC 121 on ch5
      pitch_ev(5, 8'h34, 8'h24);            // 0x1234
      cc_ev(5, 10, 8'h7F, 1);
      cc_ev(5, 120, 8'h11, 1);
      cc_ev(5, 121, 8'h00, 0);
      count_busy(n);
      chk("ch_clr busy cycles", n, 120);
      tick();
      rd(5, 10, 7'h00, 14'h0000);
      rd(5, 120, 7'h11, 14'h0880);
      chk("ovf before drop", ovf, 0);

      // Pending slot and overflow during a clear of ch6.
      cc_ev(6, 121, 8'h00, 0);
      cc_ev(7, 2, 8'h55, -1);
      cc_ev(7, 3, 8'h66, 0);
      pitch_ev(9, 8'h00, 8'h7F);            // 0x3F80, applied while busy
      tick();
      chk("ovf after drop", ovf, 1);
      chk("busy during clear", busy, 1);
      count_busy(n);
      chk("clear finished", busy, 0);
      repeat (3) tick();
      rd(7, 2, 7'h55, 14'h2A80);
      rd(7, 3, 7'h00, 14'h0000);
      chk("ovf sticky", ovf, 1);
      repeat (4) tick();
      chk("pitch queue drained", pq.size(), 0);
      chk("cc queue drained", cq.size(), 0);
      chk("read queue drained", rq.size(), 0);

      // Reset clears ovf; a reset during the init sweep restarts it from entry 0.
      reset_reg_N = 1'b0;
      for (int i = 0; i < CH; i++) model_p[i] = 14'd8192;
      @(negedge CLOCK_25);
      chk("rereset ovf", ovf, 0);
      chk("rereset busy", busy, 1);
      chk("rereset pitch_val", pitch_val, pvec());
      tick();
      reset_reg_N = 1'b1;
      repeat (100) tick();
      reset_reg_N = 1'b0;
      tick();
      reset_reg_N = 1'b1;
      count_busy(n);
      chk("restart busy cycles", n, 2048);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
